// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU-harness types and sizing helpers
package alu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_DONE
    } sar_state_t;

    localparam int SAR_N_DEFAULT = 32;

    function automatic int sar_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int SAR_IDX_W_DEFAULT = sar_idx_w(SAR_N_DEFAULT);

endpackage

// File: rtl/comparator_lt.sv
// rtl/comparator_lt.sv - signed less-than comparator (a < b)
module comparator_lt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);

    assign lt = $signed(a) < $signed(b);

endmodule

// File: rtl/sar_search.sv
// rtl/sar_search.sv - successive-approximation search driving a signed less-than compare
import alu_pkg::*;

module sar_search #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    output logic         busy,
    output logic [N-1:0] probe,
    output logic         probe_req,
    input  logic         cmp_ack,
    input  logic         cmp_lt,
    output logic [N-1:0] result,
    output logic         done
);

    localparam int IW = sar_idx_w(N);
    localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

    sar_state_t    state;
    logic [N-1:0]  code;
    logic [IW-1:0] bit_idx;
    logic [N-1:0]  result_q;
    logic [N-1:0]  code_clr;
    logic [N-1:0]  code_nxt;

    // code_clr resolves the current bit; code_nxt additionally arms the next trial bit.
    always_comb begin
        code_clr = code;
        if (cmp_lt) begin
            code_clr[bit_idx] = 1'b0;
        end
        code_nxt = code_clr;
        if (bit_idx != '0) begin
            code_nxt[bit_idx - 1'b1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            code     <= '0;
            bit_idx  <= IDX_TOP;
            result_q <= '0;
        end else if (abort) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        code    <= {1'b1, {(N-1){1'b0}}};
                        bit_idx <= IDX_TOP;
                        state   <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    if (cmp_ack) begin
                        if (bit_idx == '0) begin
                            code     <= code_clr;
                            result_q <= {~code_clr[N-1], code_clr[N-2:0]};
                            state    <= S_DONE;
                        end else begin
                            code    <= code_nxt;
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        probe     = {~code[N-1], code[N-2:0]};
        probe_req = (state == S_PROBE);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
    end

    assign result = result_q;

endmodule
